// File: rtl/scaled_line_buffer.sv
// Double-buffered scan-line buffer with integer horizontal/vertical pixel repetition.
// Optional `SCALED_LINE_BUFFER_STATUS_EN enables the sticky incomplete-fill flag.
module scaled_line_buffer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned LENGTH      = 640,
    parameter int unsigned SCALE_WIDTH = 6
) (
    input  logic                   clk_pixel,
    input  logic                   rst,
    input  logic                   frame,
    input  logic                   line,
    input  logic                   enable_input,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   enable_output,
    input  logic [SCALE_WIDTH-1:0] scale_h,
    input  logic [SCALE_WIDTH-1:0] scale_v,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   valid_out,
    output logic                   fill_request,
    output logic                   incomplete
);

    localparam int unsigned WR_AW = $clog2(LENGTH + 1);
    localparam int unsigned RD_AW = $clog2(LENGTH);

    logic [DATA_WIDTH-1:0]  bank0 [LENGTH];
    logic [DATA_WIDTH-1:0]  bank1 [LENGTH];

    logic                   rd_bank;
    logic [WR_AW-1:0]       wr_addr;
    logic [RD_AW-1:0]       rd_addr;
    logic [SCALE_WIDTH-1:0] h_cnt;
    logic [SCALE_WIDTH-1:0] v_cnt;

    logic [SCALE_WIDTH-1:0] eff_h;
    logic [SCALE_WIDTH-1:0] eff_v;
    logic                   h_wrap;
    logic                   v_last;
    logic                   swap;
    logic                   wr_full;
    logic                   wr_accept;
    logic [WR_AW-1:0]       wr_addr_nxt;
    logic [DATA_WIDTH-1:0]  rd_word;

    // Scale decode, swap detection and write-pointer next state.
    always_comb begin
        eff_h       = (scale_h == '0) ? SCALE_WIDTH'(1) : scale_h;
        eff_v       = (scale_v == '0) ? SCALE_WIDTH'(1) : scale_v;
        h_wrap      = (h_cnt == eff_h - SCALE_WIDTH'(1));
        v_last      = (v_cnt == eff_v - SCALE_WIDTH'(1));
        swap        = frame | (line & v_last);
        wr_full     = (wr_addr == WR_AW'(LENGTH));
        wr_accept   = enable_input & ~wr_full & ~swap;
        wr_addr_nxt = wr_addr;
        if (swap) begin
            wr_addr_nxt = '0;
        end else if (wr_accept) begin
            wr_addr_nxt = wr_addr + WR_AW'(1);
        end
        rd_word = rd_bank ? bank1[rd_addr] : bank0[rd_addr];
    end

    // Line storage; the write bank is always the one not being displayed.
    always_ff @(posedge clk_pixel) begin
        if (wr_accept) begin
            if (rd_bank) begin
                bank0[RD_AW'(wr_addr)] <= data_in;
            end else begin
                bank1[RD_AW'(wr_addr)] <= data_in;
            end
        end
    end

    // Pointers, counters and registered outputs.
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            data_out     <= '0;
            valid_out    <= 1'b0;
            fill_request <= 1'b1;
            rd_bank      <= 1'b0;
            wr_addr      <= '0;
            rd_addr      <= '0;
            h_cnt        <= '0;
            v_cnt        <= '0;
        end else begin
            data_out     <= rd_word;
            valid_out    <= enable_output;
            wr_addr      <= wr_addr_nxt;
            fill_request <= (wr_addr_nxt != WR_AW'(LENGTH));
            if (frame | line) begin
                rd_addr <= '0;
                h_cnt   <= '0;
                if (swap) begin
                    rd_bank <= ~rd_bank;
                    v_cnt   <= '0;
                end else begin
                    v_cnt   <= v_cnt + SCALE_WIDTH'(1);
                end
            end else if (enable_output) begin
                if (h_wrap) begin
                    h_cnt <= '0;
                    // Hold on the last pixel once the line runs out.
                    if (rd_addr != RD_AW'(LENGTH - 1)) begin
                        rd_addr <= rd_addr + RD_AW'(1);
                    end
                end else begin
                    h_cnt <= h_cnt + SCALE_WIDTH'(1);
                end
            end
        end
    end

`ifdef SCALED_LINE_BUFFER_STATUS_EN
    // Flags a swap that happened before the write bank was completely filled.
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            incomplete <= 1'b0;
        end else if (frame) begin
            incomplete <= ~wr_full;
        end else if (swap) begin
            incomplete <= incomplete | ~wr_full;
        end
    end
`else
    assign incomplete = 1'b0;
`endif

endmodule

// File: tb/tb_scaled_line_buffer.sv
// Bench for scaled_line_buffer: directed scaling/overflow/status cases plus a random run,
// all checked against a pixel-index model of what each display cycle must show.
module tb_scaled_line_buffer;

    localparam int L = 640;

    logic       clk_pixel = 1'b0;
    logic       rst = 1'b1;
    logic       frame = 1'b0;
    logic       line = 1'b0;
    logic       enable_input = 1'b0;
    logic [7:0] data_in = '0;
    logic       enable_output = 1'b0;
    logic [5:0] scale_h = 6'd2;
    logic [5:0] scale_v = 6'd2;
    logic [7:0] data_out;
    logic       valid_out;
    logic       fill_request;
    logic       incomplete;

    scaled_line_buffer dut (
        .clk_pixel     (clk_pixel),
        .rst           (rst),
        .frame         (frame),
        .line          (line),
        .enable_input  (enable_input),
        .data_in       (data_in),
        .enable_output (enable_output),
        .scale_h       (scale_h),
        .scale_v       (scale_v),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .fill_request  (fill_request),
        .incomplete    (incomplete)
    );

    always #5 clk_pixel = ~clk_pixel;

    int vectors = 0;
    int errors  = 0;

    // Model: the line being filled, the line being shown, and display progress.
    logic [7:0] pend [L];
    bit         pend_k [L];
    logic [7:0] shown [L];
    bit         shown_k [L];
    int         pend_cnt;
    int         k;
    int         lines;
    bit         inc_m;

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < L; i++) begin
            pend_k[i]  = 1'b0;
            shown_k[i] = 1'b0;
        end
        pend_cnt = 0;
        k        = 0;
        lines    = 0;
        inc_m    = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input bit fr, input bit ln, input bit ei, input logic [7:0] di, input bit eo);
        int eh, ev, idx;
        bit sw, exp_dk;
        logic [7:0] exp_data;
        frame = fr; line = ln; enable_input = ei; data_in = di; enable_output = eo;
        eh  = (scale_h == 0) ? 1 : int'(scale_h);
        ev  = (scale_v == 0) ? 1 : int'(scale_v);
        idx = k / eh;
        if (idx > L - 1) idx = L - 1;
        exp_dk   = eo && shown_k[idx];
        exp_data = shown[idx];
        sw = fr || (ln && (lines == ev - 1));
        if (ei && !sw && pend_cnt < L) begin
            pend[pend_cnt]   = di;
            pend_k[pend_cnt] = 1'b1;
            pend_cnt++;
        end
        if (fr || ln) k = 0;
        else if (eo) k++;
        if (fr) lines = 0;
        else if (ln) lines = sw ? 0 : lines + 1;
        if (sw) begin
`ifdef SCALED_LINE_BUFFER_STATUS_EN
            if (fr) inc_m = (pend_cnt != L);
            else    inc_m = inc_m || (pend_cnt != L);
`endif
            for (int i = 0; i < L; i++) begin
                shown[i]   = pend[i];
                shown_k[i] = pend_k[i];
                pend_k[i]  = 1'b0;
            end
            pend_cnt = 0;
        end
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        check("valid_out", int'(valid_out), int'(eo));
        if (exp_dk) check("data_out", int'(data_out), int'(exp_data));
        check("fill_request", int'(fill_request), int'(pend_cnt != L));
        check("incomplete", int'(incomplete), int'(inc_m));
    endtask

    task automatic reset_check();
        check("rst_data_out", int'(data_out), 0);
        check("rst_valid_out", int'(valid_out), 0);
        check("rst_fill_request", int'(fill_request), 1);
        check("rst_incomplete", int'(incomplete), 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk_pixel);
        reset_check();
        rst = 1'b0;

        // Fill with 700 writes; only the first 640 land.
        for (int i = 0; i < 700; i++) begin
            step(0, 0, 1, i[7:0], 0);
            if (i == 638) check("fill_before_640", int'(fill_request), 1);
            if (i == 639) check("fill_after_640", int'(fill_request), 0);
        end
        step(1, 0, 0, 8'h00, 0);
        check("fill_after_frame", int'(fill_request), 1);

        // scale_h=2: every pixel twice, last pixel held past the line end.
        for (int j = 0; j < 1300; j++) begin
            step(0, 0, 0, 8'h00, 1);
            if (j == 0 || j == 1 || j == 2 || j == 513 || j == 1279 || j == 1299)
                check("hscale_lit", int'(data_out), (j < 1280) ? (j / 2) % 256 : 127);
        end

        // scale_h=0 acts as 1; line does not swap with scale_v=2.
        scale_h = 6'd0;
        step(0, 1, 0, 8'h00, 0);
        for (int j = 0; j < 700; j++) begin
            step(0, 0, 0, 8'h00, 1);
            if (j == 0 || j == 255 || j == 256 || j == 639 || j == 699)
                check("sat_lit", int'(data_out), (j < 640) ? j % 256 : 127);
        end

        // scale_v=3: two replays, then the third line swaps.
        for (int i = 0; i < L; i++) step(0, 0, 1, 8'((i * 7 + 3) % 256), 0);
        scale_v = 6'd3;
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < L; i++) step(0, 0, 1, 8'($urandom), 0);
        check("vscale_filled", int'(fill_request), 0);
        for (int r = 0; r < 2; r++) begin
            step(0, 1, 0, 8'h00, 0);
            for (int j = 0; j < 20; j++) begin
                step(0, 0, 0, 8'h00, 1);
                check("vscale_replay", int'(data_out), (j * 7 + 3) % 256);
            end
            check("vscale_no_swap", int'(fill_request), 0);
        end
        step(0, 1, 0, 8'h00, 0);
        check("vscale_swap", int'(fill_request), 1);

        // Short fill followed by a swapping line.
        scale_v = 6'd1;
        for (int i = 0; i < 100; i++) step(0, 0, 1, 8'(i), 0);
        step(0, 1, 0, 8'h00, 0);
`ifdef SCALED_LINE_BUFFER_STATUS_EN
        check("incomplete_set", int'(incomplete), 1);
`else
        check("incomplete_set", int'(incomplete), 0);
`endif
        for (int i = 0; i < L; i++) step(0, 0, 1, 8'(i), 0);
        step(1, 0, 0, 8'h00, 0);
        check("incomplete_clear", int'(incomplete), 0);

        // Random traffic; scales only change right after a frame.
        for (int c = 0; c < 20000; c++) begin
            bit fr;
            fr = ($urandom % 500) == 0;
            step(fr, ($urandom % 150) == 0, ($urandom % 10) < 8, 8'($urandom),
                 ($urandom % 10) < 8);
            if (fr) begin
                scale_h = 6'($urandom % 4);
                scale_v = 6'($urandom % 4);
            end
        end

        // Asynchronous reset in the middle of a line.
        step(0, 0, 1, 8'h55, 1);
        #2 rst = 1'b1;
        @(negedge clk_pixel);
        reset_check();
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) step(0, 0, 1, 8'(i), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/scaled_line_buffer.md
# scaled_line_buffer

Double-buffered, single-clock scan-line buffer with independent horizontal and vertical integer scaling. The fill side writes one source line into the write bank while the display side reads the other bank, each pixel repeated `scale_h` times and each line repeated `scale_v` times. Banks swap only when a line has been shown `scale_v` times, and the block requests the next source line at that point. It sits between the frame-fetch logic and the pixel output stage of the video path.

## Interface
- `DATA_WIDTH`, 8: pixel width in bits.
- `LENGTH`, 640: pixels per bank.
- `SCALE_WIDTH`, 6: width of `scale_h` and `scale_v`.

Ports:
- `clk_pixel` in 1: the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `frame` in 1: start-of-frame pulse.
- `line` in 1: start-of-output-line pulse.
- `enable_input` in 1: write `data_in` at the write pointer.
- `data_in` in DATA_WIDTH: source pixel.
- `enable_output` in 1: advance the read side this cycle.
- `scale_h` in SCALE_WIDTH: horizontal repeat count.
- `scale_v` in SCALE_WIDTH: vertical repeat count.
- `data_out` out DATA_WIDTH: registered pixel.
- `valid_out` out 1: `data_out` corresponds to an `enable_output` cycle.
- `fill_request` out 1: the write bank needs a new line.
- `incomplete` out 1: sticky status flag (see Configuration).

## Operation
**Storage**
- Two banks of `LENGTH` × `DATA_WIDTH`.
- `rd_bank` selects the bank being read; the write bank is `~rd_bank`.
- Memory contents are not reset.

**Effective scale**
- A scale value of 0 is treated as 1 (`eff = (s==0)?1:s`).

**Write side**
- `wr_addr` is `$clog2(LENGTH+1)` bits wide.
- If `enable_input` is high and `wr_addr < LENGTH`: write to bank `~rd_bank` at `wr_addr`, then `wr_addr++`.
- If `enable_input` is high and `wr_addr == LENGTH`: the write is ignored and `wr_addr` holds.

**Read side**
- Each `enable_output` cycle:
  - If `h_cnt == eff_h-1`: `h_cnt <= 0`; `rd_addr++` unless `rd_addr == LENGTH-1`, where it saturates and the last pixel repeats.
  - Otherwise: `h_cnt++`.

**Line event** (`line` high, `frame` low)
- Always: `rd_addr <= 0`, `h_cnt <= 0`.
- If `v_cnt == eff_v-1`, this is a swap:
  - `rd_bank` toggles, `v_cnt <= 0`, `wr_addr <= 0`.
- Otherwise: `v_cnt++`.

**Frame event** (`frame` high)
- Performs the line event with a forced swap.
- `v_cnt <= 0`.
- Clears `incomplete`.

**Outputs**
- `fill_request = (wr_addr != LENGTH)`.

**Priority**
- `rst` > `frame` > `line` > `enable_input`/`enable_output` counter updates.
- A write in a swap cycle is discarded.
- A read in a line/frame cycle still samples the pre-event `rd_addr`/`rd_bank` (see Timing).

## Timing
**Reset values**
- `data_out = 0`, `valid_out = 0`, `fill_request = 1`, `incomplete = 0`.
- `rd_bank = 0`, `wr_addr = 0`, `rd_addr = 0`, `h_cnt = 0`, `v_cnt = 0`.

**Read latency**
- `data_out <= bank[rd_bank][rd_addr]` registered on every clock, using pre-update pointer values.
- `valid_out <= enable_output`. One cycle of latency.

**Swap and write timing**
- A swap is visible the cycle after the `line`/`frame` pulse: `fill_request` rises, and the first `data_out` from the new read bank appears two cycles after the pulse, given `enable_output`.
- A write accepted in cycle N is readable after the next swap.
- `fill_request` falls the cycle after the `LENGTH`th accepted write.

**Reset mid-operation**
- Asynchronous reset returns all registers to reset values immediately.
- Bank contents are undefined to the reader until refilled.

## Configuration
- `SCALED_LINE_BUFFER_STATUS_EN` defined:
  - At a swap, `incomplete` sets if `wr_addr != LENGTH`. This covers both `line` and `frame` swaps, evaluated before `wr_addr` resets.
  - `incomplete` is sticky until `rst` or `frame`. A `frame` that also sets it leaves it set.
- Not defined:
  - `incomplete` is tied to 0 and no comparison logic is synthesised.

## Test plan
- **Reset**: assert `rst` mid-line → next cycle `data_out=0`, `valid_out=0`, `fill_request=1`, `incomplete=0`.
- **Horizontal scaling**:
  - Stimulus: write 0..639 (mod 256), `frame`, then `enable_output` held with `scale_h=2`.
  - Required: `data_out` = 0,0,1,1,2,2… starting two cycles after `frame`; `valid_out` follows `enable_output` one cycle late.
- **Vertical scaling**:
  - Stimulus: `scale_v=3`, bank filled after a swap.
  - Required: the next two `line` pulses replay the same data and `fill_request` stays 0. The third pulse swaps and `fill_request` goes to 1.
- **Saturation and zero scale**: `scale_h=0` with more than 640 enables → one pixel per cycle, `data_out` holds pixel 639 after address 639.
- **Write overflow**: 700 writes → pixels 640..699 are ignored, `fill_request` falls after the 640th write, and the displayed line matches the first 640.
- **Incomplete fill**:
  - Stimulus: only 100 writes, then a swapping `line`.
  - Required: with `SCALED_LINE_BUFFER_STATUS_EN`, `incomplete=1` until `frame`; without the macro, `incomplete=0`.
